// File: rtl/mem_arbiter_fsm.sv
// Arbiter for the single unified RAM port shared by instruction fetch and data memory.
// Data has priority, with a bounded streak before a fetch is forced; stuck or errored RAM transactions lock into ERROR.
module mem_arbiter_fsm #(
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [ADDR_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              dwait,
    output logic [ADDR_W-1:0] dload,
    input  logic              halt,
    output logic              halt_done,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned STK_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_D = 2'd1,
        ST_GNT_I = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [STK_W-1:0]   streak_q, streak_d;

    logic dreq;
    logic starve;
    logic gnt_live;
    logic d_live, i_live;
    logic d_done, i_done;

    assign dreq   = dREN | dWEN;
    assign starve = (streak_q == STK_W'(STARVE_MAX)) & iREN & ~halt;

    // Next-state, timeout and streak bookkeeping
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        streak_d = streak_q;
        gnt_live = (state_q == ST_GNT_D) ? dreq : iREN;
        case (state_q)
            ST_IDLE: begin
                if (dreq && !starve) begin
                    state_d  = ST_GNT_D;
                    tmo_d    = '0;
                    if (!iREN) begin
                        streak_d = '0;
                    end else if (streak_q != STK_W'(STARVE_MAX)) begin
                        streak_d = streak_q + STK_W'(1);
                    end
                end else if (iREN && !halt) begin
                    state_d  = ST_GNT_I;
                    tmo_d    = '0;
                    streak_d = '0;
                end
            end
            ST_GNT_D, ST_GNT_I: begin
                if (!gnt_live || ramstate == RS_ACCESS) begin
                    state_d = ST_IDLE;
                end else if (ramstate == RS_ERROR || tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = ST_ERROR;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            tmo_q    <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            streak_q <= streak_d;
        end
    end

    // RAM port follows the live granted request so a withdrawal or reset drops enables at once
    assign d_live = (state_q == ST_GNT_D) & dreq;
    assign i_live = (state_q == ST_GNT_I) & iREN;
    assign d_done = d_live & (ramstate == RS_ACCESS);
    assign i_done = i_live & (ramstate == RS_ACCESS);

    assign ramWEN    = d_live & dWEN;
    assign ramREN    = (d_live & ~dWEN) | i_live;
    assign ramaddr   = d_live ? daddr : (i_live ? iaddr : '0);
    assign ramstore  = (d_live & dWEN) ? dstore : '0;
    assign dwait     = dreq & ~d_done;
    assign iwait     = iREN & ~i_done;
    assign dload     = d_done ? ramload : '0;
    assign iload     = i_done ? ramload : '0;
    assign err       = (state_q == ST_ERROR);
    assign halt_done = (state_q == ST_IDLE) & halt & ~err;

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Randomized bench for mem_arbiter_fsm against a transaction-level reference model.
// A few directed scenarios lead into a long random run.
module tb_mem_arbiter_fsm;

    localparam int unsigned TMO  = 8;
    localparam int unsigned SMAX = 4;
    localparam int unsigned AW   = 32;

    logic          CLK;
    logic          RST;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          iwait;
    logic [AW-1:0] iload;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [AW-1:0] dstore;
    logic          dwait;
    logic [AW-1:0] dload;
    logic          halt;
    logic          halt_done;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [AW-1:0] ramstore;
    logic [AW-1:0] ramload;
    logic [1:0]    ramstate;
    logic          err;

    mem_arbiter_fsm #(.TIMEOUT(TMO), .STARVE_MAX(SMAX), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .halt(halt), .halt_done(halt_done),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: who holds the port (0 none, 1 data, 2 fetch, 3 dead),
    // consecutive data wins over a waiting fetch, and cycles spent stalled.
    int owner;
    int streak;
    int stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner  = 0;
        streak = 0;
        stall  = 0;
    endtask

    task automatic model_step();
        logic dreq;
        logic live;
        dreq = dREN | dWEN;
        if (owner == 0) begin
            if (dreq && !(streak == SMAX && iREN && !halt)) begin
                owner  = 1;
                stall  = 0;
                streak = iREN ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
            end else if (iREN && !halt) begin
                owner  = 2;
                stall  = 0;
                streak = 0;
            end
        end else if (owner == 1 || owner == 2) begin
            live = (owner == 1) ? dreq : iREN;
            if (!live || ramstate == 2'd2) begin
                owner = 0;
            end else if (ramstate == 2'd3) begin
                owner = 3;
            end else begin
                stall++;
                if (stall >= TMO) owner = 3;
            end
        end
    endtask

    task automatic check_outputs();
        logic          dreq, dl, il, acc;
        logic [AW-1:0] e_addr, e_store;
        if (RST) model_reset();
        dreq    = dREN | dWEN;
        dl      = (owner == 1) && dreq;
        il      = (owner == 2) && iREN;
        acc     = (ramstate == 2'd2);
        e_addr  = dl ? daddr : (il ? iaddr : '0);
        e_store = (dl && dWEN) ? dstore : '0;
        #1;
        chk("ramWEN",    32'(ramWEN),    32'(dl && dWEN));
        chk("ramREN",    32'(ramREN),    32'((dl && !dWEN) || il));
        chk("ramaddr",   ramaddr,        e_addr);
        chk("ramstore",  ramstore,       e_store);
        chk("dwait",     32'(dwait),     32'(dreq && !(dl && acc)));
        chk("iwait",     32'(iwait),     32'(iREN && !(il && acc)));
        chk("iload",     iload,          (il && acc) ? ramload : '0);
        if (!dWEN) chk("dload", dload,   (dl && acc) ? ramload : '0);
        chk("halt_done", 32'(halt_done), 32'(owner == 0 && halt));
        chk("err",       32'(err),       32'(owner == 3));
    endtask

    task automatic tick();
        @(posedge CLK);
        if (!RST) model_step();
        @(negedge CLK);
    endtask

    int first_i;
    int stall_left;
    logic dq;
    int r;

    initial begin
        RST = 1'b1; iREN = 1'b1; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; halt = 1'b0; ramload = '0; ramstate = 2'd1;
        model_reset();
        @(negedge CLK);
        check_outputs();
        tick();
        RST = 1'b0; iREN = 1'b0;
        check_outputs();
        tick();

        // Single fetch completing on its second grant cycle
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd1;
        check_outputs(); tick();
        check_outputs();
        chk("fetch_ramaddr", ramaddr, 32'h40);
        tick();
        ramstate = 2'd2; ramload = 32'h8C010004;
        check_outputs();
        chk("fetch_iload", iload, 32'h8C010004);
        chk("fetch_iwait", 32'(iwait), 32'd0);
        tick();
        iREN = 1'b0; ramstate = 2'd0;
        check_outputs(); tick();

        // Contention: write wins, fetch follows
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        ramstate = 2'd1;
        check_outputs(); tick();
        ramstate = 2'd2;
        check_outputs();
        chk("cont_wen", 32'(ramWEN), 32'd1);
        chk("cont_store", ramstore, 32'hDEADBEEF);
        tick();
        dWEN = 1'b0; ramstate = 2'd1;
        check_outputs(); tick();
        check_outputs();
        chk("cont_igrant", ramaddr, 32'h44);
        ramstate = 2'd2;
        check_outputs(); tick();
        iREN = 1'b0; ramstate = 2'd0;
        check_outputs(); tick();

        // Starvation: four data grants then a forced fetch
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200; ramstate = 2'd2;
        first_i = -1;
        for (int c = 0; c < 12; c++) begin
            check_outputs();
            if (!iwait && first_i < 0) begin
                first_i = c;
                chk("starve_dwait_held", 32'(dwait), 32'd1);
            end
            tick();
        end
        chk("starve_first_igrant", 32'(first_i), 32'd9);
        iREN = 1'b0; dREN = 1'b0; ramstate = 2'd0;
        check_outputs(); tick();

        // Halt: pending data served, fetch never granted
        halt = 1'b1; iREN = 1'b1; dREN = 1'b1; daddr = 32'h210; ramstate = 2'd1;
        check_outputs(); tick();
        ramstate = 2'd2; ramload = 32'h1234_5678;
        check_outputs(); tick();
        dREN = 1'b0; ramstate = 2'd0;
        check_outputs();
        chk("halt_done", 32'(halt_done), 32'd1);
        chk("halt_iwait", 32'(iwait), 32'd1);
        tick();
        check_outputs();
        chk("halt_no_igrant", 32'(ramREN), 32'd0);
        tick();
        halt = 1'b0; iREN = 1'b0;
        check_outputs(); tick();

        // Timeout: write stuck BUSY for TMO grant cycles
        dWEN = 1'b1; daddr = 32'h300; ramstate = 2'd1;
        check_outputs(); tick();
        for (int c = 0; c < TMO; c++) begin
            check_outputs(); tick();
        end
        check_outputs();
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_wen", 32'(ramWEN), 32'd0);
        RST = 1'b1;
        check_outputs();
        chk("rst_err_clear", 32'(err), 32'd0);
        tick();
        RST = 1'b0; dWEN = 1'b0;
        check_outputs(); tick();

        // Withdrawal of a fetch while BUSY
        iREN = 1'b1; iaddr = 32'h50; ramstate = 2'd1;
        check_outputs(); tick();
        check_outputs();
        iREN = 1'b0;
        check_outputs();
        chk("wd_ren", 32'(ramREN), 32'd0);
        tick();
        check_outputs(); tick();

        // Reset in the middle of a data write
        dWEN = 1'b1; daddr = 32'h400; dstore = 32'hCAFEF00D; ramstate = 2'd1;
        check_outputs(); tick();
        check_outputs();
        RST = 1'b1;
        check_outputs();
        chk("rst_async_wen", 32'(ramWEN), 32'd0);
        tick();
        RST = 1'b0; dWEN = 1'b0;
        check_outputs(); tick();

        // Random traffic
        stall_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (RST) RST = 1'b0;
            else if ($urandom_range(0, 299) == 0) RST = 1'b1;
            else if (owner == 3 && $urandom_range(0, 7) == 0) RST = 1'b1;
            iREN = ($urandom_range(0, 9) < (iREN ? 9 : 4));
            dq = ($urandom_range(0, 9) < ((dREN | dWEN) ? 8 : 4));
            dWEN = dq & 1'($urandom_range(0, 1));
            dREN = dq & (~dWEN | ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            if (stall_left > 0) begin
                ramstate = 2'd1;
                stall_left--;
            end else begin
                r = $urandom_range(0, 99);
                ramstate = (r < 1) ? 2'd3 : (r < 45) ? 2'd2 : (r < 75) ? 2'd1 : 2'd0;
                if ($urandom_range(0, 59) == 0) stall_left = 12;
            end
            check_outputs();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
